// File: rtl/coeff_sequencer.sv
// coeff_sequencer: streams one stored 5x5 kernel per frame, aligned to the delayed vsync,
// with a register-file config port that stalls only writes to the kernel being streamed.
module coeff_sequencer #(
  parameter int NUM_KERNELS = 4,
  parameter int COEFF_W = 16,
  parameter int TAPS = 25,
  localparam int KW = $clog2(NUM_KERNELS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vs_i,
  input  logic               hs_i,
  input  logic               dv_i,
  output logic               vs_o,
  output logic               hs_o,
  output logic               dv_o,
  output logic [COEFF_W-1:0] coeff_o,
  input  logic [KW-1:0]      sel_i,
  input  logic               cfg_we,
  input  logic [KW-1:0]      cfg_kernel,
  input  logic [4:0]         cfg_idx,
  input  logic [COEFF_W-1:0] cfg_data,
  output logic               cfg_ready_o,
  output logic               cfg_err_o,
  output logic               load_done_o,
  output logic               frame_err_o,
  output logic [KW-1:0]      active_o
);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
  state_t state, state_n;
  logic [4:0] n;
  logic vs_prev, rise, last, wr_ok;
  logic [COEFF_W-1:0] k [NUM_KERNELS][TAPS];
  assign rise = vs_i && !vs_prev;
  assign last = n == 5'(TAPS - 1);
  assign cfg_ready_o = !(state == LOAD && cfg_kernel == active_o);
  assign wr_ok = cfg_we && cfg_ready_o;
  always_comb begin
    state_n = state == IDLE ? (rise ? LOAD : IDLE) :
              state == LOAD ? (!vs_i ? IDLE : last ? HOLD : LOAD) :
              (vs_i ? HOLD : IDLE);
    load_done_o = !rst && state == LOAD && vs_i && last;
    coeff_o = state == LOAD ? k[active_o][n] : '0;
  end
  // vs_prev resets high so a vsync held across reset is not mistaken for a new frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n <= '0;
      active_o <= '0;
      {vs_o, hs_o, dv_o} <= '0;
      vs_prev <= 1'b1;
      cfg_err_o <= 1'b0;
      frame_err_o <= 1'b0;
      for (int i = 0; i < NUM_KERNELS; i++)
        for (int j = 0; j < TAPS; j++)
          k[i][j] <= (i == 0 && j == 12) ? COEFF_W'(256) : '0;
    end else begin
      state <= state_n;
      n <= state == LOAD ? n + 5'd1 : '0;
      if (state == IDLE && rise) active_o <= sel_i;
      {vs_o, hs_o, dv_o} <= {vs_i, hs_i, dv_i};
      vs_prev <= vs_i;
      cfg_err_o <= wr_ok && cfg_idx >= 5'(TAPS);
      frame_err_o <= state == LOAD && !vs_i;
      if (wr_ok && cfg_idx < 5'(TAPS)) k[cfg_kernel][cfg_idx] <= cfg_data;
    end
  end
endmodule

// File: tb/tb_coeff_sequencer.sv
// tb_coeff_sequencer: directed frames against a coefficient model, per-cycle scoreboard.
module tb_coeff_sequencer;
  logic clk = 0, rst = 1, vs_i = 0, hs_i = 0, dv_i = 0, cfg_we = 0;
  logic [1:0] sel_i = 0, cfg_kernel = 0, active_o;
  logic [4:0] cfg_idx = 0;
  logic [15:0] cfg_data = 0, coeff_o;
  logic vs_o, hs_o, dv_o, cfg_ready_o, cfg_err_o, load_done_o, frame_err_o;
  int checks = 0, errors = 0, stall;
  logic [15:0] kern [4][25];
  typedef struct {logic [15:0] c; logic v, h, d, ld, fe;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  coeff_sequencer dut (
    .clk(clk), .rst(rst), .vs_i(vs_i), .hs_i(hs_i), .dv_i(dv_i),
    .vs_o(vs_o), .hs_o(hs_o), .dv_o(dv_o), .coeff_o(coeff_o), .sel_i(sel_i),
    .cfg_we(cfg_we), .cfg_kernel(cfg_kernel), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_ready_o(cfg_ready_o), .cfg_err_o(cfg_err_o), .load_done_o(load_done_o),
    .frame_err_o(frame_err_o), .active_o(active_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (q.size() > 0) begin
    exp_t e;
    e = q.pop_front();
    chk("coeff", coeff_o, e.c);
    chk("vs_o", vs_o, e.v);
    chk("hs_o", hs_o, e.h);
    chk("dv_o", dv_o, e.d);
    chk("load_done", load_done_o, e.ld);
    chk("frame_err", frame_err_o, e.fe);
  end

  task automatic model_reset();
    foreach (kern[i, j]) kern[i][j] = 16'h0;
    kern[0][12] = 16'h0100;
  endtask

  task automatic frame(input logic [1:0] sel, input logic [1:0] sel_mid, input int len);
    logic ph, pd;
    exp_t e;
    ph = hs_i;
    pd = dv_i;
    for (int j = 0; j < len + 3; j++) begin
      @(posedge clk); #1;
      vs_i = j < len;
      hs_i = j[0];
      dv_i = (j % 3) == 0;
      sel_i = j < 5 ? sel : sel_mid;
      e.c = (j >= 1 && j - 1 < len && j - 1 < 25) ? kern[sel][j-1] : 16'h0;
      e.v = j >= 1 && j <= len;
      e.h = ph;
      e.d = pd;
      e.ld = len >= 26 && j == 25;
      e.fe = len <= 25 && j == len + 1;
      q.push_back(e);
      ph = hs_i;
      pd = dv_i;
    end
    chk("active", active_o, sel);
  endtask

  task automatic wr(input logic [1:0] kk, input logic [4:0] idx, input logic [15:0] d);
    @(posedge clk); #1;
    cfg_we = 1; cfg_kernel = kk; cfg_idx = idx; cfg_data = d;
    @(negedge clk); chk("cfg_ready", cfg_ready_o, 1);
    @(posedge clk); #1;
    cfg_we = 0;
    if (idx < 25) kern[kk][idx] = d;
    @(negedge clk); chk("cfg_err", cfg_err_o, idx >= 25);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_coeff", coeff_o, 0);
    chk("rst_vs_o", vs_o, 0);
    chk("rst_load_done", load_done_o, 0);
    chk("rst_frame_err", frame_err_o, 0);
    chk("rst_cfg_err", cfg_err_o, 0);
    chk("rst_active", active_o, 0);
    chk("rst_ready", cfg_ready_o, 1);
    @(posedge clk); #1 rst = 0;
    frame(0, 0, 40);
    for (int i = 0; i < 25; i++) wr(2, 5'(i), 16'(i + 1));
    frame(2, 2, 30);
    frame(0, 0, 10);
    fork
      frame(1, 1, 40);
      begin
        repeat (4) @(posedge clk); #1;
        cfg_we = 1; cfg_kernel = 3; cfg_idx = 0; cfg_data = 16'h0777;
        @(negedge clk); chk("rdy_other", cfg_ready_o, 1);
        @(posedge clk);
        kern[3][0] = 16'h0777;
        #1 cfg_kernel = 1; cfg_idx = 3; cfg_data = 16'h0333;
        stall = 0;
        @(negedge clk);
        while (!cfg_ready_o && stall < 60) begin
          stall++;
          @(negedge clk);
        end
        chk("stall", stall, 22);
        @(posedge clk);
        kern[1][3] = 16'h0333;
        #1 cfg_we = 0;
      end
    join
    frame(1, 1, 30);
    frame(3, 3, 30);
    wr(2, 25, 16'hdead);
    @(negedge clk); chk("cfg_err_once", cfg_err_o, 0);
    frame(2, 2, 30);
    frame(0, 1, 30);
    frame(1, 1, 30);
    @(posedge clk); #1 vs_i = 1;
    repeat (5) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_coeff", coeff_o, 0);
    chk("rst_mid_fe", frame_err_o, 0);
    @(posedge clk); #1 rst = 0;
    model_reset();
    repeat (5) begin
      @(negedge clk);
      chk("no_reload", coeff_o, 0);
      chk("no_reload_fe", frame_err_o, 0);
      chk("no_reload_ld", load_done_o, 0);
    end
    @(posedge clk); #1 vs_i = 0;
    frame(0, 0, 30);
    frame(1, 1, 27);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
